sram_like_arbiter: RTL and testbench

Two-to-one arbiter sharing a single sram-like memory port between the instruction-fetch requester (the PreIF/IF pair) and the data-access requester (MEM stage). It forwards one request per handshake, records the owner of every accepted request in an in-order tag FIFO, and routes each `data_ok` back to its owner. On a pipeline flush it cancels outstanding instruction responses so that stale fetch data never reaches IF.

---
 rtl/sram_like_arbiter_pkg.sv | 10 +
 rtl/arb_tag_fifo.sv | 39 +++
 rtl/sram_like_arbiter.sv | 77 +++++++
 tb/tb_sram_like_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: owner ids, tag-entry type and size encoding shared by the arbiter slice
package sram_like_arbiter_pkg;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef struct packed {
    logic id;
    logic cancel;
  } tag_t;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order owner-tag FIFO; ports: i_push/i_tag write, i_pop advance head, i_cancel_inst marks every inst entry cancelled, o_head/o_full/o_empty status
module arb_tag_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  tag_t i_tag,
  input  logic i_pop,
  input  logic i_cancel_inst,
  output tag_t o_head,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  tag_t r_mem [DEPTH];
  assign o_empty = r_wptr == r_rptr;
  assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head = r_mem[r_rptr[AW-1:0]];
  // Broadcast cancel runs first so a same-cycle push keeps the tag the top computed for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_cancel_inst && r_mem[i].id == ID_INST) r_mem[i].cancel <= 1'b1;
      if (i_push && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_tag;
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like port between inst fetch and data access; ports: inst_*/data_* requester sides, req_o..wdata_o/addr_ok_i/data_ok_i/rdata_i memory side, excep_flush_i cancels pending fetches
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                excep_flush_i,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic                inst_addr_ok_o,
  output logic                inst_data_ok_o,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                data_req_i,
  input  logic                data_wr_i,
  input  logic [1:0]          data_size_i,
  input  logic [DATA_W/8-1:0] data_wstrb_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_addr_ok_o,
  output logic                data_data_ok_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                req_o,
  output logic                wr_o,
  output logic [1:0]          size_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic                addr_ok_i,
  input  logic                data_ok_i,
  input  logic [DATA_W-1:0]   rdata_i
);
  logic r_lock_vld, r_lock_id;
  logic w_grant, w_is_data, w_push, w_pop, w_full, w_empty;
  tag_t w_head, w_tag;
  // A locked grant must stay on the bus until accepted, even if priority would now differ.
  assign w_grant = r_lock_vld ? r_lock_id : (data_req_i ? ID_DATA : ID_INST);
  assign w_is_data = w_grant == ID_DATA;
  assign req_o = !rst && !w_full && (r_lock_vld || data_req_i || inst_req_i);
  assign wr_o = w_is_data ? data_wr_i : 1'b0;
  assign size_o = w_is_data ? data_size_i : SIZE_WORD;
  assign wstrb_o = w_is_data ? data_wstrb_i : '0;
  assign addr_o = w_is_data ? data_addr_i : inst_addr_i;
  assign wdata_o = data_wdata_i;
  assign w_push = req_o && addr_ok_i;
  assign inst_addr_ok_o = w_push && !w_is_data;
  assign data_addr_ok_o = w_push && w_is_data;
  assign w_tag = '{id: w_grant, cancel: !w_is_data && excep_flush_i};
  assign w_pop = !rst && data_ok_i && !w_empty;
  assign data_data_ok_o = w_pop && w_head.id == ID_DATA;
  assign inst_data_ok_o = w_pop && w_head.id == ID_INST && !w_head.cancel && !excep_flush_i;
  assign inst_rdata_o = rdata_i;
  assign data_rdata_o = rdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_vld <= 1'b0;
      r_lock_id <= ID_INST;
    end else begin
      r_lock_vld <= req_o && !addr_ok_i;
      r_lock_id <= w_grant;
    end
  end
  arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_tag        (w_tag),
    .i_pop        (w_pop),
    .i_cancel_inst(excep_flush_i),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: scoreboard bench for sram_like_arbiter
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;
  localparam logic [31:0] IADDR = 32'h1C00_0000;
  localparam logic [31:0] DADDR = 32'h8000_0010;
  logic clk = 0, rst = 1, excep_flush_i = 0;
  logic inst_req_i = 0, inst_addr_ok_o, inst_data_ok_o;
  logic [31:0] inst_addr_i = IADDR, inst_rdata_o;
  logic data_req_i = 0, data_wr_i = 1, data_addr_ok_o, data_data_ok_o;
  logic [1:0] data_size_i = 2'b01;
  logic [3:0] data_wstrb_i = 4'b0011;
  logic [31:0] data_addr_i = DADDR, data_wdata_i = 32'hCAFE_F00D, data_rdata_o;
  logic req_o, wr_o, addr_ok_i = 0, data_ok_i = 0;
  logic [1:0] size_o;
  logic [3:0] wstrb_o;
  logic [31:0] addr_o, wdata_o, rdata_i = 0;
  int n_chk = 0, n_pass = 0;
  tag_t sb[$];
  logic m_lock = 0, m_own = 0;
  always #5 clk = ~clk;
  sram_like_arbiter dut (
    .clk(clk), .rst(rst), .excep_flush_i(excep_flush_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_addr_ok_o(inst_addr_ok_o),
    .inst_data_ok_o(inst_data_ok_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_size_i(data_size_i),
    .data_wstrb_i(data_wstrb_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o), .data_rdata_o(data_rdata_o),
    .req_o(req_o), .wr_o(wr_o), .size_o(size_o), .wstrb_o(wstrb_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  // One cycle: drive inputs after the edge, compare mid-cycle, then advance the reference model.
  task automatic step(input logic ir, input logic dr, input logic aok, input logic dok,
                      input logic fl, input logic [31:0] rd);
    logic e_req, e_own, e_iok, e_dok;
    tag_t e;
    @(posedge clk); #1;
    inst_req_i = ir; data_req_i = dr; addr_ok_i = aok; data_ok_i = dok; excep_flush_i = fl; rdata_i = rd;
    #1;
    e_own = m_lock ? m_own : dr;
    e_req = (m_lock || dr || ir) && sb.size() < 4;
    chk("req_o", req_o, e_req);
    if (e_req) begin
      chk("addr_o", addr_o, e_own ? DADDR : IADDR);
      chk("wr_o", wr_o, e_own);
      chk("size_o", size_o, e_own ? 2'b01 : SIZE_WORD);
      chk("wstrb_o", wstrb_o, e_own ? 4'b0011 : 4'b0000);
    end
    chk("inst_addr_ok", inst_addr_ok_o, e_req && aok && !e_own);
    chk("data_addr_ok", data_addr_ok_o, e_req && aok && e_own);
    e_iok = 0; e_dok = 0;
    if (dok && sb.size() > 0) begin
      e = sb.pop_front();
      e_dok = e.id;
      e_iok = !e.id && !e.cancel && !fl;
    end
    chk("inst_data_ok", inst_data_ok_o, e_iok);
    chk("data_data_ok", data_data_ok_o, e_dok);
    if (e_iok) chk("inst_rdata", inst_rdata_o, rd);
    if (e_dok) chk("data_rdata", data_rdata_o, rd);
    if (fl) foreach (sb[i]) if (!sb[i].id) sb[i].cancel = 1;
    if (e_req && aok) sb.push_back('{id: e_own, cancel: !e_own && fl});
    m_lock = e_req && !aok;
    m_own = e_own;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; inst_req_i = 1; data_req_i = 1; addr_ok_i = 1; data_ok_i = 1; excep_flush_i = 0;
    #1;
    chk("rst req_o", req_o, 0);
    chk("rst inst_addr_ok", inst_addr_ok_o, 0);
    chk("rst data_addr_ok", data_addr_ok_o, 0);
    chk("rst inst_data_ok", inst_data_ok_o, 0);
    chk("rst data_data_ok", data_data_ok_o, 0);
    @(posedge clk); #1;
    rst = 0; inst_req_i = 0; data_req_i = 0; addr_ok_i = 0; data_ok_i = 0;
    sb.delete();
    m_lock = 0;
  endtask
  initial begin
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h1111_1111);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h0280_0C0C);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hAAAA_0001);
    step(0, 0, 0, 1, 0, 32'hAAAA_0002);
    step(1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 32'hB000_0000 + i);
    for (int i = 0; i < 4; i++) step(i[0], !i[0], 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 32'hC000_0000);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 1; i < 5; i++) step(0, 0, 0, 1, 0, 32'hC000_0000 + i);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 32'hD000_0000 + i);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hD000_00FF);
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 32'hE000_0001);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'hE000_0002);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hE000_0003);
    step(0, 0, 0, 1, 0, 32'hE000_0004);
    step(1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 0, 32'hF000_0001);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hF000_0002);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
